// File: rtl/sensor_scan_if.sv
// Bus bundle between the sensor scan sequencer and its surroundings (mux, thresholds, alarm consumer).
// With SCAN_PEAK_EN defined the bundle also carries peak_clr, peak0 and peak1.
interface sensor_scan_if;
  logic       start;
  logic [7:0] mux_out;
  logic [7:0] lo_th0;
  logic [7:0] hi_th0;
  logic [7:0] lo_th1;
  logic [7:0] hi_th1;
  logic       sel;
  logic [7:0] sample0;
  logic [7:0] sample1;
  logic       valid;
  logic       valid_ch;
  logic       alarm0;
  logic       alarm1;
  logic       busy;
`ifdef SCAN_PEAK_EN
  logic       peak_clr;
  logic [7:0] peak0;
  logic [7:0] peak1;

  modport master (
    output start, mux_out, lo_th0, hi_th0, lo_th1, hi_th1, peak_clr,
    input  sel, sample0, sample1, valid, valid_ch, alarm0, alarm1, busy, peak0, peak1
  );
  modport slave (
    input  start, mux_out, lo_th0, hi_th0, lo_th1, hi_th1, peak_clr,
    output sel, sample0, sample1, valid, valid_ch, alarm0, alarm1, busy, peak0, peak1
  );
`else
  modport master (
    output start, mux_out, lo_th0, hi_th0, lo_th1, hi_th1,
    input  sel, sample0, sample1, valid, valid_ch, alarm0, alarm1, busy
  );
  modport slave (
    input  start, mux_out, lo_th0, hi_th0, lo_th1, hi_th1,
    output sel, sample0, sample1, valid, valid_ch, alarm0, alarm1, busy
  );
`endif
endinterface

// File: rtl/sensor_scan_ctrl.sv
// Two-channel sensor scan sequencer: select, settle, capture, range-check, alarm with persistence.
// Optional peak tracking (peak_clr/peak0/peak1) is built when SCAN_PEAK_EN is defined.
module sensor_scan_ctrl #(
  parameter int SETTLE  = 2,
  parameter int PERSIST = 3,
  parameter int CW      = 4
) (
  input  logic         clk,
  input  logic         rst,
  sensor_scan_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [CW-1:0] SETTLE_C   = CW'(SETTLE);
  localparam logic [CW-1:0] PERSIST_M1 = CW'(PERSIST - 1);

  // Returns {alarm, cnt} after one sample; a disagreeing sample is in range while alarmed or out while not.
  function automatic logic [CW:0] persist_next(input logic alarm, input logic [CW-1:0] cnt,
                                               input logic in_rng);
    logic [CW:0] r;
    if (in_rng != alarm) begin
      r = {alarm, {CW{1'b0}}};
    end else if (cnt == PERSIST_M1) begin
      r = {~alarm, {CW{1'b0}}};
    end else begin
      r = {alarm, cnt + CW'(1)};
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          ch_q, ch_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [7:0]    sample0_q, sample0_d, sample1_q, sample1_d;
  logic          alarm0_q, alarm0_d, alarm1_q, alarm1_d;
  logic [CW-1:0] pcnt0_q, pcnt0_d, pcnt1_q, pcnt1_d;
  logic          valid_q, valid_d, valid_ch_q, valid_ch_d, busy_q, busy_d;
  logic [7:0]    chk_val, chk_lo, chk_hi;
  logic          in_rng;

  // Next-state, capture and alarm persistence.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    scnt_d    = scnt_q;
    sample0_d = sample0_q;
    sample1_d = sample1_q;
    alarm0_d  = alarm0_q;
    alarm1_d  = alarm1_q;
    pcnt0_d   = pcnt0_q;
    pcnt1_d   = pcnt1_q;
    chk_val   = ch_q ? sample1_q  : sample0_q;
    chk_lo    = ch_q ? bus.lo_th1 : bus.lo_th0;
    chk_hi    = ch_q ? bus.hi_th1 : bus.hi_th0;
    in_rng    = (chk_lo <= chk_val) && (chk_val <= chk_hi);
    case (state_q)
      ST_IDLE: begin
        ch_d = 1'b0;
        if (bus.start) begin
          if (SETTLE_C == {CW{1'b0}}) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
            scnt_d  = SETTLE_C;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (scnt_q <= CW'(1)) begin
          state_d = ST_CAPTURE;
          scnt_d  = {CW{1'b0}};
        end else begin
          scnt_d  = scnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_CHECK;
        if (ch_q) begin
          sample1_d = bus.mux_out;
        end else begin
          sample0_d = bus.mux_out;
        end
      end
      ST_CHECK: begin
        if (ch_q) begin
          {alarm1_d, pcnt1_d} = persist_next(alarm1_q, pcnt1_q, in_rng);
        end else begin
          {alarm0_d, pcnt0_d} = persist_next(alarm0_q, pcnt0_q, in_rng);
        end
        if (bus.start) begin
          ch_d = ~ch_q;
          if (SETTLE_C == {CW{1'b0}}) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
            scnt_d  = SETTLE_C;
          end
        end else begin
          ch_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = 1'b0;
      end
    endcase
    valid_d    = (state_d == ST_CHECK);
    valid_ch_d = ch_d;
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= 1'b0;
      scnt_q     <= {CW{1'b0}};
      sample0_q  <= 8'd0;
      sample1_q  <= 8'd0;
      alarm0_q   <= 1'b0;
      alarm1_q   <= 1'b0;
      pcnt0_q    <= {CW{1'b0}};
      pcnt1_q    <= {CW{1'b0}};
      valid_q    <= 1'b0;
      valid_ch_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      scnt_q     <= scnt_d;
      sample0_q  <= sample0_d;
      sample1_q  <= sample1_d;
      alarm0_q   <= alarm0_d;
      alarm1_q   <= alarm1_d;
      pcnt0_q    <= pcnt0_d;
      pcnt1_q    <= pcnt1_d;
      valid_q    <= valid_d;
      valid_ch_q <= valid_ch_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.sel      = ch_q;
  assign bus.sample0  = sample0_q;
  assign bus.sample1  = sample1_q;
  assign bus.valid    = valid_q;
  assign bus.valid_ch = valid_ch_q;
  assign bus.alarm0   = alarm0_q;
  assign bus.alarm1   = alarm1_q;
  assign bus.busy     = busy_q;

`ifdef SCAN_PEAK_EN
  logic [7:0] peak0_q, peak0_d, peak1_q, peak1_d;

  // Peak tracking; a clear wins over a same-cycle update.
  always_comb begin
    peak0_d = peak0_q;
    peak1_d = peak1_q;
    if (bus.peak_clr) begin
      peak0_d = 8'd0;
      peak1_d = 8'd0;
    end else if (state_q == ST_CHECK) begin
      if (ch_q) begin
        peak1_d = (sample1_q > peak1_q) ? sample1_q : peak1_q;
      end else begin
        peak0_d = (sample0_q > peak0_q) ? sample0_q : peak0_q;
      end
    end else begin
      peak0_d = peak0_q;
    end
  end

  // Peak registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak0_q <= 8'd0;
      peak1_q <= 8'd0;
    end else begin
      peak0_q <= peak0_d;
      peak1_q <= peak1_d;
    end
  end

  assign bus.peak0 = peak0_q;
  assign bus.peak1 = peak1_q;
`endif

endmodule
